tap_decoder: RTL

TAP_DECODER -- requirements
Module: tap_decoder

---
 rtl/tap_pkg.sv | 33 +++
 rtl/tap_gap_timer.sv | 31 +++
 rtl/tap_decoder.sv | 112 +++++++++++
 3 files changed

// File: rtl/tap_pkg.sv
// tap_pkg: shared FSM state encoding, event codes and tap limit for tap_decoder.
// Build option: define TAP_DECODER_TRIPLE_EN to enable triple-tap detection
// (otherwise the second tap emits a double event immediately).
package tap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        EMIT   = 2'd2
    } tap_state_t;

    localparam logic [1:0] TAP_NONE   = 2'b00;
    localparam logic [1:0] TAP_SINGLE = 2'b01;
    localparam logic [1:0] TAP_DOUBLE = 2'b10;
    localparam logic [1:0] TAP_TRIPLE = 2'b11;

`ifdef TAP_DECODER_TRIPLE_EN
    localparam logic [1:0] MAX_TAPS = 2'd3;
`else
    localparam logic [1:0] MAX_TAPS = 2'd2;
`endif

    // Map a gathered tap count onto the event code presented to the consumer.
    function automatic logic [1:0] tap_code(input logic [1:0] taps);
        case (taps)
            2'd1:    return TAP_SINGLE;
            2'd2:    return TAP_DOUBLE;
            2'd3:    return TAP_TRIPLE;
            default: return TAP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/tap_gap_timer.sv
// tap_gap_timer: counts idle cycles between taps; saturates at GAP_CYCLES-1
// and flags expiry there, so it can never wrap.
module tap_gap_timer #(
    parameter int GAP_CYCLES   = 12500000,
    parameter int COUNTERWIDTH = 32
) (
    input  logic clk_50MHz,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [COUNTERWIDTH-1:0] LAST = COUNTERWIDTH'(GAP_CYCLES - 1);

    logic [COUNTERWIDTH-1:0] cnt;

    assign expired = (cnt == LAST);

    // Gap counter: clear wins, otherwise count up while enabled until the last value.
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tap_decoder.sv
// tap_decoder: groups one-cycle press pulses into single/double(/triple) tap
// events separated by at most GAP_CYCLES cycles, and hands each event to a
// valid/ready consumer. Presses arriving while an event is pending are
// counted in drop_cnt (saturating).
// Build option: TAP_DECODER_TRIPLE_EN enables triple taps (see tap_pkg).
module tap_decoder
    import tap_pkg::*;
#(
    parameter int GAP_CYCLES   = 12500000,
    parameter int COUNTERWIDTH = 32
) (
    input  logic       clk_50MHz,
    input  logic       rst_n,
    input  logic       press_pulse,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    tap_state_t state;
    logic [1:0] taps;
    logic       timer_clear;
    logic       timer_en;
    logic       expired;
    logic       handshake;

    // The timer only runs while gathering; every press restarts the gap.
    assign timer_en    = (state == GATHER);
    assign timer_clear = (state != GATHER) || press_pulse;
    assign handshake   = evt_valid && evt_ready;

    tap_gap_timer #(
        .GAP_CYCLES   (GAP_CYCLES),
        .COUNTERWIDTH (COUNTERWIDTH)
    ) u_gap_timer (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .clear     (timer_clear),
        .enable    (timer_en),
        .expired   (expired)
    );

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Tap FSM with registered event, busy and drop-counter outputs.
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            taps      <= 2'd0;
            evt_valid <= 1'b0;
            evt_code  <= TAP_NONE;
            busy      <= 1'b0;
            drop_cnt  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (press_pulse) begin
                        state <= GATHER;
                        taps  <= 2'd1;
                        busy  <= 1'b1;
                    end
                end
                GATHER: begin
                    // A press on the timeout cycle still counts as a tap.
                    if (press_pulse) begin
                        if (taps + 2'd1 == MAX_TAPS) begin
                            state     <= EMIT;
                            taps      <= 2'd0;
                            evt_valid <= 1'b1;
                            evt_code  <= tap_code(MAX_TAPS);
                        end else begin
                            taps <= taps + 2'd1;
                        end
                    end else if (expired) begin
                        state     <= EMIT;
                        taps      <= 2'd0;
                        evt_valid <= 1'b1;
                        evt_code  <= tap_code(taps);
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        evt_valid <= 1'b0;
                        evt_code  <= TAP_NONE;
                        // A press on the handshake cycle starts the next gesture.
                        if (press_pulse) begin
                            state <= GATHER;
                            taps  <= 2'd1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (press_pulse) begin
                        drop_cnt <= sat_inc8(drop_cnt);
                    end
                end
                default: begin
                    state     <= IDLE;
                    taps      <= 2'd0;
                    evt_valid <= 1'b0;
                    evt_code  <= TAP_NONE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
